bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
Time-multiplexed seven-segment display driver that sits directly downstream of the BCD adder.
- Captures the adder's NDIG-digit BCD sum and its decimal carry-out on a load strobe.
- Scans the captured value onto NDIG+1 common-select digit positions: NDIG sum digits plus one carry position.
- Provides leading-zero blanking, an invalid-digit error flag, and a frame pulse.

Parameters:
NDIG, 2, number of BCD sum digits captured (carry position is additional), NDIG >= 1
DIV, 4, clocks each digit position stays selected, DIV >= 1
BLANK_LZ, 1, 1 = blank leading zero digits, 0 = show all sum digits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
load  input  1  capture strobe, one cycle
bcd_in  input  4*NDIG  BCD sum, digit 0 = bcd_in[3:0] (least significant)
carry_in  input  1  decimal carry-out of the adder
seg  output  7  segments {g,f,e,d,c,b,a}, active high
an  output  NDIG+1  one-hot position select, bit NDIG = carry position, active high
err  output  1  captured value contains a digit > 9
frame  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: held digits = 0, held carry = 0, prescaler = 0, pos = 0, en = 0.
- Reset outputs: seg = 7'h00, an = 0, err = 0, frame = 0.
- Reset asserted mid-scan: everything clears on the next edge and the display stays blank until the next load.
- Load:
  - On load, bcd_in and carry_in are registered into the held value and en is set to 1.
  - New data is visible on seg the cycle after load.
  - Load does not disturb the prescaler or pos.
  - Back-to-back loads each overwrite the held value.
- Prescaler:
  - Counts 0..DIV-1. tick = (prescaler == DIV-1); on tick the prescaler wraps to 0.
  - On tick, pos advances 0 -> 1 -> ... -> NDIG -> 0.
  - With DIV = 1, tick is asserted every cycle.
  - The prescaler and pos run regardless of en.
- Selection outputs:
  - an and seg are combinational from registered state (pos, held data, en).
  - en = 0: an = 0, seg = 0.
  - en = 1: an = one-hot(pos).
- Sum positions (pos < NDIG), seg = decode(held digit[pos]):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - 10..15 = 79 ("E").
- Carry position (pos = NDIG): seg = 06 if held carry = 1, else 00. an is still asserted.
- Leading-zero blanking (BLANK_LZ = 1):
  - A sum digit k >= 1 shows seg = 00 if it and all higher sum digits are 0 and held carry = 0.
  - Digit 0 is never blanked.
  - Invalid digits count as nonzero.
- err:
  - Registered; updated on every load to the OR over captured digits of (digit > 9).
  - Cleared only by reset or by a load of a valid value.
- frame:
  - Registered; equals 1 for the cycle after a tick with pos = NDIG, only when en = 1.
  - Period is (NDIG+1)*DIV cycles.
- Simultaneous load and tick: both take effect; the next cycle shows the new data at the new pos.
- Width rules: prescaler width = clog2(DIV) (min 1); pos width = clog2(NDIG+1) (min 1).

Decomposition:
- Shared package holds:
  - segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK;
  - the segment bit order;
  - the DIV/NDIG legality checks.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit BCD to 7-segment decoder that emits SEG_E for codes 10..15. It is instantiated once on the muxed digit.

Test Plan (NDIG = 2, DIV = 4, BLANK_LZ = 1):
- Reset: rst high 3 cycles, then 20 cycles with no load -> an = 000, seg = 00, err = 0, frame = 0 throughout.
- Basic scan: load bcd_in = 8'h47, carry_in = 0 -> scan shows an = 001/seg = 07, then 010/66, then 100/00, each held 4 cycles. frame pulses every 12 cycles.
- Carry shown: load 8'h05, carry_in = 1 -> positions show 6D, 3F (zero not blanked because carry = 1), and 06.
- All zero: load 8'h00, carry_in = 0 -> positions show 3F, 00, 00.
- Invalid digit: load 8'hA3 -> err = 1 from the next cycle; positions show 4F, 79, 00. A following load of 8'h12 -> err = 0; positions show 5B, 06, 00.
- Boundary events: load asserted on a tick cycle -> the new value appears at the advanced pos next cycle. rst asserted while an = 010 -> next cycle an = 0, seg = 0, and the display stays blank until a reload.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the BCD scan display: segment layout, glyph constants
// and parameter legality checks.
package bcd_display_scan_pkg;

   // Segment vector layout, msb first; active high.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg7_t;

   localparam seg7_t SEG_0     = 7'h3F;
   localparam seg7_t SEG_1     = 7'h06;
   localparam seg7_t SEG_2     = 7'h5B;
   localparam seg7_t SEG_3     = 7'h4F;
   localparam seg7_t SEG_4     = 7'h66;
   localparam seg7_t SEG_5     = 7'h6D;
   localparam seg7_t SEG_6     = 7'h7D;
   localparam seg7_t SEG_7     = 7'h07;
   localparam seg7_t SEG_8     = 7'h7F;
   localparam seg7_t SEG_9     = 7'h6F;
   localparam seg7_t SEG_E     = 7'h79;
   localparam seg7_t SEG_BLANK = 7'h00;

   function automatic bit params_legal(input int ndig, input int div);
      return (ndig >= 1) && (div >= 1);
   endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes above 9 render as "E".
module bcd_to_seg7
   import bcd_display_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output seg7_t      seg
);

   always_comb begin
      seg = SEG_E;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment driver for a captured BCD sum plus carry,
// with leading-zero blanking, invalid-digit flag and end-of-scan pulse.
module bcd_display_scan
   import bcd_display_scan_pkg::*;
#(
   parameter int NDIG     = 2,
   parameter int DIV      = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [4*NDIG-1:0] bcd_in,
   input  logic              carry_in,
   output logic [6:0]        seg,
   output logic [NDIG:0]     an,
   output logic              err,
   output logic              frame
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int QW = ($clog2(NDIG + 1) > 0) ? $clog2(NDIG + 1) : 1;

   generate
      if (!params_legal(NDIG, DIV)) begin : g_bad_params
         $error("bcd_display_scan: NDIG and DIV must both be >= 1");
      end
   endgenerate

   logic [PW-1:0]     presc_reg, presc_next;
   logic [QW-1:0]     pos_reg, pos_next;
   logic [4*NDIG-1:0] digits_reg;
   logic              carry_reg, en_reg, err_reg, frame_reg;
   logic              tick, at_carry;
   logic [NDIG-1:0]   bad_in, blank_vec;
   logic [3:0]        sel_digit;
   logic              sel_blank;
   seg7_t             dec_seg;

   assign tick     = (presc_reg == PW'(DIV - 1));
   assign at_carry = (pos_reg == QW'(NDIG));

   // Per-digit validity of incoming data and blanking of the held value.
   // A digit is blanked when it and everything above it are zero and no carry.
   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_digit
         assign bad_in[gi] = (bcd_in[4*gi +: 4] > 4'd9);
         if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = (BLANK_LZ != 0) && !carry_reg &&
                                   (digits_reg[4*NDIG-1:4*gi] == '0);
         end
      end
      for (gi = 0; gi <= NDIG; gi++) begin : g_an
         assign an[gi] = en_reg && (pos_reg == QW'(gi));
      end
   endgenerate

   always_comb begin
      presc_next = tick ? '0 : presc_reg + 1'b1;
      pos_next   = pos_reg;
      if (tick) begin
         pos_next = at_carry ? '0 : pos_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_reg  <= '0;
         pos_reg    <= '0;
         digits_reg <= '0;
         carry_reg  <= 1'b0;
         en_reg     <= 1'b0;
         err_reg    <= 1'b0;
         frame_reg  <= 1'b0;
      end else begin
         presc_reg <= presc_next;
         pos_reg   <= pos_next;
         frame_reg <= tick && at_carry && en_reg;
         if (load) begin
            digits_reg <= bcd_in;
            carry_reg  <= carry_in;
            en_reg     <= 1'b1;
            err_reg    <= |bad_in;
         end
      end
   end

   always_comb begin
      sel_digit = 4'd0;
      sel_blank = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         if (pos_reg == QW'(k)) begin
            sel_digit = digits_reg[4*k +: 4];
            sel_blank = blank_vec[k];
         end
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (sel_digit),
      .seg (dec_seg)
   );

   always_comb begin
      seg = SEG_BLANK;
      if (en_reg) begin
         if (at_carry) begin
            seg = carry_reg ? SEG_1 : SEG_BLANK;
         end else if (!sel_blank) begin
            seg = dec_seg;
         end
      end
   end

   assign err   = err_reg;
   assign frame = frame_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan (NDIG=2, DIV=4, BLANK_LZ=1): table vectors,
// corner sequences and random traffic against a cycle-count based model.
module tb_bcd_display_scan;

   localparam int NDIG = 2;
   localparam int DIV  = 4;
   localparam int NPOS = NDIG + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] bcd_in = 8'h00;
   logic       carry_in = 1'b0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       err, frame;

   int total = 0;
   int bad = 0;

   bcd_display_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK_LZ(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .bcd_in   (bcd_in),
      .carry_in (carry_in),
      .seg      (seg),
      .an       (an),
      .err      (err),
      .frame    (frame)
   );

   always #5 clk = ~clk;

   // Model: position follows purely from edges elapsed since reset.
   int         n = 0;
   logic [7:0] m_held = 8'h00;
   bit         m_carry = 0, m_en = 0, m_err = 0, m_frame = 0;
   logic [6:0] glyph [16];

   typedef struct {
      logic [7:0] bcd;
      bit         carry;
      logic [6:0] s [NPOS];
      bit         e;
   } vec_t;
   vec_t vecs [5];

   task automatic cmp(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s n=%0d got=%0h want=%0h", name, n, got, want);
      end
   endtask

   function automatic int model_pos();
      return (n / DIV) % NPOS;
   endfunction

   function automatic logic [6:0] model_seg();
      int p = model_pos();
      int d;
      if (!m_en) return 7'h00;
      if (p == NDIG) return m_carry ? 7'h06 : 7'h00;
      d = (m_held >> (4 * p)) & 4'hF;
      if (p >= 1 && (m_held >> (4 * p)) == 0 && !m_carry) return 7'h00;
      return glyph[d];
   endfunction

   task automatic check();
      logic [2:0] an_exp;
      an_exp = m_en ? 3'(1 << model_pos()) : 3'b000;
      cmp("an", int'(an), int'(an_exp));
      cmp("seg", int'(seg), int'(model_seg()));
      cmp("err", int'(err), int'(m_err));
      cmp("frame", int'(frame), int'(m_frame));
   endtask

   task automatic step(input bit ld, input logic [7:0] b, input bit c, input bit r);
      rst = r; load = ld; bcd_in = b; carry_in = c;
      @(posedge clk);
      if (r) begin
         n = 0; m_held = 0; m_carry = 0; m_en = 0; m_err = 0; m_frame = 0;
      end else begin
         n++;
         m_frame = (n % (NPOS * DIV) == 0) && m_en;
         if (ld) begin
            m_held  = b;
            m_carry = c;
            m_en    = 1;
            m_err   = (b[3:0] > 4'd9) || (b[7:4] > 4'd9);
         end
      end
      #1;
      check();
      $display("cyc n=%0d rst=%0b load=%0b bcd=%02h c=%0b -> an=%03b seg=%02h err=%0b frame=%0b",
               n, r, ld, b, c, an, seg, err, frame);
      rst = 0; load = 0;
   endtask

   initial begin
      bit found;
      glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
      vecs[0] = '{8'h47, 0, '{7'h07, 7'h66, 7'h00}, 0};
      vecs[1] = '{8'h05, 1, '{7'h6D, 7'h3F, 7'h06}, 0};
      vecs[2] = '{8'h00, 0, '{7'h3F, 7'h00, 7'h00}, 0};
      vecs[3] = '{8'hA3, 0, '{7'h4F, 7'h79, 7'h00}, 1};
      vecs[4] = '{8'h12, 0, '{7'h5B, 7'h06, 7'h00}, 0};

      // Reset then idle: display must stay dark.
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0);

      // Table vectors: each held for two full scans.
      foreach (vecs[v]) begin
         step(1, vecs[v].bcd, vecs[v].carry, 0);
         for (int i = 0; i < 2 * NPOS * DIV; i++) begin
            cmp("tbl_seg", int'(seg), int'(vecs[v].s[model_pos()]));
            cmp("tbl_err", int'(err), int'(vecs[v].e));
            step(0, 8'h00, 0, 0);
         end
      end

      // Load coinciding with a tick.
      for (int i = 0; i < DIV && (n % DIV) != DIV - 1; i++) step(0, 8'h00, 0, 0);
      cmp("pre_tick", n % DIV, DIV - 1);
      step(1, 8'h98, 0, 0);
      for (int i = 0; i < NPOS * DIV; i++) step(0, 8'h00, 0, 0);

      // Reset while the middle position is selected.
      found = 0;
      for (int i = 0; i < 2 * NPOS * DIV && !found; i++) begin
         if (an == 3'b010) found = 1;
         else step(0, 8'h00, 0, 0);
      end
      cmp("found_an010", int'(found), 1);
      step(0, 8'h00, 0, 1);
      cmp("rst_an", int'(an), 0);
      cmp("rst_seg", int'(seg), 0);
      for (int i = 0; i < 2 * NPOS * DIV; i++) step(0, 8'h00, 0, 0);
      step(1, 8'h31, 1, 0);
      for (int i = 0; i < NPOS * DIV; i++) step(0, 8'h00, 0, 0);

      // Random traffic, including invalid digits and occasional resets.
      for (int i = 0; i < 400; i++) begin
         bit ld = ($urandom_range(0, 4) == 0);
         bit r  = ($urandom_range(0, 59) == 0);
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) b[7:4] = 4'h0;
         step(ld, b, 1'($urandom_range(0, 1)), r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
